flag_handshake_tx: RTL and testbench

Source-side initiator for the toggle-based clock-domain-crossing handshake: accepts a data word on a valid/ready port, launches it as a level toggle on `req_toggle`, and holds `data_out` stable until the far end returns an acknowledge toggle. The block sits in the sending clock domain, in front of a toggle-synchronizing receiver in the other domain. It resynchronizes the returning acknowledge locally and provides backpressure, so no event is lost, unlike a fire-and-forget flag crossing.

---
 rtl/flag_handshake_tx_pkg.sv | 14 +
 rtl/toggle_edge_sync.sv | 35 +++
 rtl/flag_handshake_tx.sv | 132 +++++++++++++
 tb/tb_flag_handshake_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_handshake_tx_pkg.sv
// Shared definitions for the toggle-handshake transmitter and its reusable
// acknowledge synchronizer.
//   fht_state_e  : transmitter state (IDLE / WAIT_ACK)
//   FHT_SYNC_MIN : smallest legal synchronizer depth
package flag_handshake_tx_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } fht_state_e;

  localparam int FHT_SYNC_MIN = 2;

endpackage

// File: rtl/toggle_edge_sync.sv
// Toggle-to-pulse synchronizer. An asynchronous level toggle is passed through
// SYNC_STAGES flops, then a history flop. Each edge of the input produces one
// single-cycle pulse, decoded from flops only.
// Ports:
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset, clears every flop
//   asyncIn : toggle from the other domain
//   pulse   : one-cycle pulse per input edge
module toggle_edge_sync
  import flag_handshake_tx_pkg::*;
#(
  parameter int SYNC_STAGES = FHT_SYNC_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic asyncIn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   histQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= '0;
      histQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], asyncIn};
      histQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign pulse = syncQ[SYNC_STAGES-1] ^ histQ;

endmodule

// File: rtl/flag_handshake_tx.sv
// Source side of a toggle-based CDC handshake. A word accepted on the
// valid/ready port is latched onto data_out and announced by flipping
// req_toggle. data_out stays frozen until the far end returns an acknowledge
// toggle, which is resynchronized locally and turned into the done pulse.
// Optional build macro FLAG_HANDSHAKE_TX_BUFFER_EN adds a one-entry holding
// register so the next word can be taken while a transfer is in flight.
// Ports:
//   clk, rst_n        : sending-domain clock, async active-low reset
//   in_valid/in_ready : input handshake, accept = in_valid & in_ready
//   in_data           : offered word
//   req_toggle        : flips once per launched transfer
//   data_out          : bundled data, stable from launch until acknowledge
//   ack_toggle_async  : far-end acknowledge toggle (asynchronous)
//   done              : one-cycle pulse per acknowledged transfer
//   proto_err         : sticky, an acknowledge edge arrived while idle
module flag_handshake_tx
  import flag_handshake_tx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_toggle,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_toggle_async,
  output logic              done,
  output logic              proto_err
);

  generate
    if (SYNC_STAGES < FHT_SYNC_MIN) begin : gSyncChk
      $error("flag_handshake_tx: SYNC_STAGES must be >= %0d", FHT_SYNC_MIN);
    end
  endgenerate

  fht_state_e state;
  logic       ackSeen;
  logic       accept;

  toggle_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uAckSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .asyncIn(ack_toggle_async),
    .pulse  (ackSeen)
  );

  assign accept = in_valid & in_ready;
  // ackSeen is a flop XOR, so done has no path from any input pin.
  assign done   = (state == WAIT_ACK) & ackSeen;

`ifdef FLAG_HANDSHAKE_TX_BUFFER_EN
  logic              bufValid;
  logic [DATA_W-1:0] bufData;

  assign in_ready = ~bufValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_toggle <= 1'b0;
      data_out   <= '0;
      proto_err  <= 1'b0;
      bufValid   <= 1'b0;
      bufData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ackSeen) proto_err <= 1'b1;
          if (accept) begin
            data_out   <= in_data;
            req_toggle <= ~req_toggle;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ackSeen) begin
            // Chain straight into the next transfer when one is pending so
            // the link never idles between back-to-back words.
            if (bufValid) begin
              data_out   <= bufData;
              req_toggle <= ~req_toggle;
              bufValid   <= 1'b0;
            end else if (accept) begin
              data_out   <= in_data;
              req_toggle <= ~req_toggle;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            bufValid <= 1'b1;
            bufData  <= in_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_toggle <= 1'b0;
      data_out   <= '0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ackSeen) proto_err <= 1'b1;
          if (accept) begin
            data_out   <= in_data;
            req_toggle <= ~req_toggle;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ackSeen) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_flag_handshake_tx.sv
// Bench for flag_handshake_tx: directed table vectors and corner sequences on
// a SYNC_STAGES=2 instance, random acknowledge delays on a SYNC_STAGES=3
// instance. Launched words are checked against a queue of accepted words.
module tb_flag_handshake_tx;

  localparam int SS   = 2;
  localparam int SS3  = 3;
  localparam int NRND = 1000;
`ifdef FLAG_HANDSHAKE_TX_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, req_toggle, ack = 1'b0, done, proto_err;
  logic [31:0] in_data = '0, data_out;
  logic        in_valid3 = 1'b0, in_ready3, req3, ack3 = 1'b0, done3, perr3;
  logic [31:0] in_data3 = '0, data3;

  always #5 clk = ~clk;

  flag_handshake_tx #(.DATA_W(32), .SYNC_STAGES(SS)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req_toggle(req_toggle), .data_out(data_out),
    .ack_toggle_async(ack), .done(done), .proto_err(proto_err));

  flag_handshake_tx #(.DATA_W(32), .SYNC_STAGES(SS3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .req_toggle(req3), .data_out(data3),
    .ack_toggle_async(ack3), .done(done3), .proto_err(perr3));

  int nChk = 0;
  int nFail = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Scoreboards: accepted words are queued, and each req flip must present
  // the oldest queued word; data_out may not move without a req flip.
  logic [31:0] sbq[$];
  logic [31:0] sbq3[$];
  logic        lastReq = 1'b0, lastReq3 = 1'b0;
  logic [31:0] lastData = '0, lastData3 = '0;
  int          doneCnt3 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lastReq  <= 1'b0;
      lastData <= '0;
      sbq.delete();
    end else begin
      if (req_toggle !== lastReq) begin
        if (sbq.size() == 0) begin
          nChk++; nFail++;
          $display("FAIL sb_launch: launch of 0x%08h with nothing accepted", data_out);
        end else chk32("sb_data_out", data_out, sbq.pop_front());
      end else chk32("sb_data_stable", data_out, lastData);
      lastReq  <= req_toggle;
      lastData <= data_out;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      lastReq3  <= 1'b0;
      lastData3 <= '0;
      sbq3.delete();
    end else begin
      if (req3 !== lastReq3) begin
        if (sbq3.size() == 0) begin
          nChk++; nFail++;
          $display("FAIL rnd_launch: launch of 0x%08h with nothing accepted", data3);
        end else chk32("rnd_data_out", data3, sbq3.pop_front());
      end else chk32("rnd_data_stable", data3, lastData3);
      if (done3) doneCnt3++;
      lastReq3  <= req3;
      lastData3 <= data3;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic offer(input logic [31:0] d, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 64; i++) begin
      if (in_ready) begin
        sbq.push_back(d);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    chk1("offer_accepted", ok, 1'b1);
  endtask

  // Toggle ack at a falling edge; done must appear exactly SS falling edges
  // later for one cycle, with in_ready high on the edge after.
  task automatic ackCheck(input string tag);
    ack = ~ack;
    for (int i = 1; i < SS; i++) begin
      @(negedge clk);
      chk1({tag, "_done_early"}, done, 1'b0);
    end
    @(negedge clk);
    chk1({tag, "_done"}, done, 1'b1);
    @(negedge clk);
    chk1({tag, "_done_once"}, done, 1'b0);
    chk1({tag, "_ready_after"}, in_ready, 1'b1);
  endtask

  typedef struct {
    logic [31:0] data;
    int          ackDly;
    logic        expReq;
  } vec_t;

  vec_t vt[6];
  bit   ok, ok5;
  int   acc3;

  initial begin
    vt[0] = '{32'hA5A5_0001, 0, 1'b1};
    vt[1] = '{32'h0000_1111, 3, 1'b0};
    vt[2] = '{32'hFFFF_FFFF, 1, 1'b1};
    vt[3] = '{32'h0000_0000, 5, 1'b0};
    vt[4] = '{32'h8000_0001, 2, 1'b1};
    vt[5] = '{32'h5A5A_F00F, 7, 1'b0};

    repeat (2) @(negedge clk);
    chk1("rst_req", req_toggle, 1'b0);
    chk32("rst_data", data_out, 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_perr", proto_err, 1'b0);
    chk1("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: launch, hold through a varied ack delay, acknowledge.
    for (int i = 0; i < 6; i++) begin
      offer(vt[i].data, ok);
      chk1("vec_req", req_toggle, vt[i].expReq);
      chk32("vec_data", data_out, vt[i].data);
      chk1("vec_ready_wait", in_ready, BUF);
      repeat (vt[i].ackDly) @(negedge clk);
      chk1("vec_ready_hold", in_ready, BUF);
      chk32("vec_data_hold", data_out, vt[i].data);
      ackCheck("vec");
    end

    // Ack edge while idle: sticky error, no state change.
    chk1("perr_clear", proto_err, 1'b0);
    ack = ~ack;
    for (int i = 0; i < SS + 3; i++) begin
      @(negedge clk);
      chk1("perr_no_done", done, 1'b0);
    end
    chk1("perr_set", proto_err, 1'b1);
    chk1("perr_req_hold", req_toggle, 1'b0);
    chk1("perr_ready", in_ready, 1'b1);
    repeat (5) @(negedge clk);
    chk1("perr_sticky", proto_err, 1'b1);

    // Reset while waiting for an acknowledge.
    offer(32'hDEAD_BEEF, ok);
    chk1("mid_req", req_toggle, 1'b1);
    chk1("mid_ready", in_ready, BUF);
    #2 rst_n = 1'b0;
    ack = 1'b0;
    #1;
    chk1("arst_req", req_toggle, 1'b0);
    chk32("arst_data", data_out, 32'h0);
    chk1("arst_perr", proto_err, 1'b0);
    chk1("arst_ready", in_ready, 1'b1);
    chk1("arst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FLAG_HANDSHAKE_TX_BUFFER_EN
    offer(32'h3, ok);
    chk1("buf_req1", req_toggle, 1'b1);
    offer(32'h4, ok);
    chk1("buf_full", in_ready, 1'b0);
    chk32("buf_hold3", data_out, 32'h3);
    fork
      offer(32'h5, ok5);
      begin
        ackCheck("buf_ack3");
        chk32("buf_relaunch4", data_out, 32'h4);
        chk1("buf_req2", req_toggle, 1'b0);
      end
    join
    chk1("buf_full5", in_ready, 1'b0);
    chk32("buf_hold4", data_out, 32'h4);
    ackCheck("buf_ack4");
    chk32("buf_relaunch5", data_out, 32'h5);
    chk1("buf_req3", req_toggle, 1'b1);
    ackCheck("buf_ack5");
`else
    // Back-to-back offers: the second word waits for done.
    in_valid = 1'b1;
    in_data  = 32'h1111;
    chk1("b2b_ready1", in_ready, 1'b1);
    sbq.push_back(32'h1111);
    @(negedge clk);
    in_data = 32'h2222;
    chk1("b2b_req1", req_toggle, 1'b1);
    repeat (3) @(negedge clk);
    chk1("b2b_blocked", in_ready, 1'b0);
    chk32("b2b_hold1", data_out, 32'h1111);
    ack = ~ack;
    begin : b2b
      bit doneSeen, acc2;
      doneSeen = 1'b0;
      acc2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (in_ready) begin
          chk1("b2b_accept_after_done", doneSeen, 1'b1);
          sbq.push_back(32'h2222);
          @(negedge clk);
          acc2 = 1'b1;
          break;
        end
        if (done) doneSeen = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk1("b2b_accepted", acc2, 1'b1);
    end
    chk1("b2b_req0", req_toggle, 1'b0);
    chk32("b2b_data2", data_out, 32'h2222);
    ackCheck("b2b_ack2");
`endif

    // Random acknowledge latency on the SYNC_STAGES=3 instance.
    acc3 = 0;
    fork
      begin : rndDrv
        for (int i = 0; i < NRND; i++) begin
          bit got;
          got = 1'b0;
          in_valid3 = 1'b1;
          in_data3  = $urandom;
          for (int w = 0; w < 200; w++) begin
            if (in_ready3) begin
              sbq3.push_back(in_data3);
              got = 1'b1;
              break;
            end
            @(negedge clk);
          end
          chk1("rnd_accept", got, 1'b1);
          if (!got) break;
          @(negedge clk);
          acc3++;
        end
        in_valid3 = 1'b0;
      end
      begin : rndRsp
        logic lr;
        int   handled;
        lr = 1'b0;
        handled = 0;
        for (int c = 0; c < 60000 && handled < NRND; c++) begin
          @(negedge clk);
          if (req3 !== lr) begin
            lr = req3;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            ack3 = ~ack3;
            handled++;
          end
        end
      end
    join
    for (int i = 0; i < 100 && doneCnt3 != acc3; i++) @(negedge clk);
    chk32("rnd_accept_count", acc3, NRND);
    chk32("rnd_done_count", doneCnt3, acc3);
    chk32("rnd_queue_empty", sbq3.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
